volume_ctrl: RTL and testbench



---
 rtl/volume_ctrl_pkg.sv | 25 ++
 rtl/volume_ctrl_key_cond.sv | 124 ++++++++++++
 rtl/volume_ctrl.sv | 120 ++++++++++++
 tb/tb_volume_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/volume_ctrl_pkg.sv
// Shared widths, key-FSM state encoding and the level-to-amplitude helper
// for the volume controller.
`timescale 1ns/1ps
package volume_ctrl_pkg;

  localparam int LEVEL_W = 4;
  localparam int AMP_W   = 16;

  typedef enum logic [1:0] {
    KEY_IDLE   = 2'd0,
    KEY_HOLD   = 2'd1,
    KEY_REPEAT = 2'd2
  } key_state_e;

  // Unsigned amplitude for a level; callers keep MAX_LEVEL*STEP <= 16'h7FFF.
  function automatic logic [AMP_W-1:0] level_to_amp(
    input logic [LEVEL_W-1:0] level,
    input logic [AMP_W-1:0]   step
  );
    logic [AMP_W-1:0] level_ext;
    level_ext = AMP_W'(level);
    return level_ext * step;
  endfunction

endpackage

// File: rtl/volume_ctrl_key_cond.sv
// One push-button conditioner: 2-flop synchronizer, tick-sampled debounce,
// and an IDLE/HOLD/REPEAT FSM that emits one-clk press and repeat pulses.
`timescale 1ns/1ps
module volume_ctrl_key_cond
  import volume_ctrl_pkg::*;
#(
  parameter int unsigned DEB_LEN    = 8,
  parameter int unsigned REPEAT_DLY = 500,
  parameter int unsigned REPEAT_PER = 100,
  parameter bit          REPEAT_EN  = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_tick,
  input  logic i_key,
  output logic o_pulse
);

  localparam int unsigned CNT_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int          CNT_W   = $clog2(CNT_MAX + 1);
  localparam int          FILL_W  = $clog2(DEB_LEN);

  logic               r_sync1;
  logic               r_sync2;
  logic [DEB_LEN-1:0] r_shift;
  logic [FILL_W-1:0]  r_fill;
  logic               r_deb;
  logic               r_armed;
  key_state_e         r_state;
  logic [CNT_W-1:0]   r_cnt;

  logic [DEB_LEN-1:0] w_shift_next;
  logic               w_fill_done;
  key_state_e         w_state_next;
  logic [CNT_W-1:0]   w_cnt_next;

  // NOTE: sequential state always uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_key;
      r_sync2 <= r_sync1;
    end
  end

  assign w_shift_next = {r_shift[DEB_LEN-2:0], r_sync2};
  assign w_fill_done  = (r_fill == FILL_W'(DEB_LEN - 1));

  // A key only arms after a full window of genuine released samples, so a key
  // held through reset must be released and pressed again before it pulses.
  // NOTE: the debounce window is reset like any flop; it is control state, not RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift <= '0;
      r_fill  <= '0;
      r_deb   <= 1'b0;
      r_armed <= 1'b0;
    end else if (i_tick) begin
      r_shift <= w_shift_next;
      if (!w_fill_done) r_fill <= r_fill + 1'b1;
      if (&w_shift_next) begin
        r_deb <= 1'b1;
      end else if (~|w_shift_next) begin
        r_deb <= 1'b0;
        if (w_fill_done) r_armed <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= KEY_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    o_pulse      = 1'b0;
    unique case (r_state)
      KEY_IDLE: begin
        if (r_deb && r_armed) begin
          o_pulse      = 1'b1;
          w_state_next = KEY_HOLD;
          w_cnt_next   = '0;
        end
      end
      KEY_HOLD: begin
        if (!r_deb) begin
          w_state_next = KEY_IDLE;
        end else if (REPEAT_EN && i_tick) begin
          if (r_cnt == CNT_W'(REPEAT_DLY - 1)) begin
            o_pulse      = 1'b1;
            w_state_next = KEY_REPEAT;
            w_cnt_next   = '0;
          end else begin
            w_cnt_next = r_cnt + 1'b1;
          end
        end
      end
      KEY_REPEAT: begin
        if (!r_deb) begin
          w_state_next = KEY_IDLE;
        end else if (i_tick) begin
          if (r_cnt == CNT_W'(REPEAT_PER - 1)) begin
            o_pulse    = 1'b1;
            w_cnt_next = '0;
          end else begin
            w_cnt_next = r_cnt + 1'b1;
          end
        end
      end
      default: w_state_next = KEY_IDLE;
    endcase
  end

endmodule

// File: rtl/volume_ctrl.sv
// Volume front-end: shared sample-tick prescaler, three conditioned keys,
// saturating level / mute state and the registered {+amp, -amp} output pair.
`timescale 1ns/1ps
module volume_ctrl
  import volume_ctrl_pkg::*;
#(
  parameter int unsigned      SAMPLE_DIV = 100000,
  parameter int unsigned      DEB_LEN    = 8,
  parameter int unsigned      REPEAT_DLY = 500,
  parameter int unsigned      REPEAT_PER = 100,
  parameter int unsigned      MAX_LEVEL  = 15,
  parameter int unsigned      DEF_LEVEL  = 8,
  parameter logic [AMP_W-1:0] STEP       = 16'h0400
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 key_up,
  input  logic                 key_down,
  input  logic                 key_mute,
  output logic [LEVEL_W-1:0]   vol_level,
  output logic                 muted,
  output logic [2*AMP_W-1:0]   vol_data
);

  localparam int               DIV_W   = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [AMP_W-1:0] DEF_AMP = level_to_amp(LEVEL_W'(DEF_LEVEL), STEP);
  localparam logic [2*AMP_W-1:0] DEF_VOL = {DEF_AMP, AMP_W'(0) - DEF_AMP};

  logic [DIV_W-1:0]   r_div_cnt;
  logic [LEVEL_W-1:0] r_level;
  logic               r_muted;
  logic [2*AMP_W-1:0] r_vol_data;

  logic               w_tick;
  logic               w_up_pulse;
  logic               w_down_pulse;
  logic               w_mute_pulse;
  logic [AMP_W-1:0]   w_amp;

  assign w_tick = (r_div_cnt == DIV_W'(SAMPLE_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt <= '0;
    end else if (w_tick) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

  volume_ctrl_key_cond #(
    .DEB_LEN   (DEB_LEN),
    .REPEAT_DLY(REPEAT_DLY),
    .REPEAT_PER(REPEAT_PER),
    .REPEAT_EN (1'b1)
  ) u_key_up (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_tick (w_tick),
    .i_key  (key_up),
    .o_pulse(w_up_pulse)
  );

  volume_ctrl_key_cond #(
    .DEB_LEN   (DEB_LEN),
    .REPEAT_DLY(REPEAT_DLY),
    .REPEAT_PER(REPEAT_PER),
    .REPEAT_EN (1'b1)
  ) u_key_down (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_tick (w_tick),
    .i_key  (key_down),
    .o_pulse(w_down_pulse)
  );

  volume_ctrl_key_cond #(
    .DEB_LEN   (DEB_LEN),
    .REPEAT_DLY(REPEAT_DLY),
    .REPEAT_PER(REPEAT_PER),
    .REPEAT_EN (1'b0)
  ) u_key_mute (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_tick (w_tick),
    .i_key  (key_mute),
    .o_pulse(w_mute_pulse)
  );

  // Opposing up/down pulses cancel; mute toggles independently of both.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_level <= LEVEL_W'(DEF_LEVEL);
      r_muted <= 1'b0;
    end else begin
      if (w_up_pulse && !w_down_pulse && (r_level < LEVEL_W'(MAX_LEVEL))) begin
        r_level <= r_level + 1'b1;
      end else if (w_down_pulse && !w_up_pulse && (r_level != '0)) begin
        r_level <= r_level - 1'b1;
      end
      if (w_mute_pulse) r_muted <= ~r_muted;
    end
  end

  assign w_amp = r_muted ? '0 : level_to_amp(r_level, STEP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vol_data <= DEF_VOL;
    end else begin
      r_vol_data <= {w_amp, AMP_W'(0) - w_amp};
    end
  end

  assign vol_level = r_level;
  assign muted     = r_muted;
  assign vol_data  = r_vol_data;

endmodule

// File: tb/tb_volume_ctrl.sv
// Self-checking bench for volume_ctrl: directed scenarios plus random key
// traffic, compared every cycle against a tick-level behavioural model.
`timescale 1ns/1ps
module tb_volume_ctrl;

  localparam int          SD   = 4;
  localparam int          DL   = 4;
  localparam int          RD   = 8;
  localparam int          RP   = 4;
  localparam int          MAXL = 15;
  localparam int          DEFL = 8;
  localparam logic [15:0] STEP = 16'h0400;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b0;
  logic        key_up   = 1'b0;
  logic        key_down = 1'b0;
  logic        key_mute = 1'b0;
  logic [3:0]  vol_level;
  logic        muted;
  logic [31:0] vol_data;

  volume_ctrl #(
    .SAMPLE_DIV(SD),
    .DEB_LEN   (DL),
    .REPEAT_DLY(RD),
    .REPEAT_PER(RP),
    .MAX_LEVEL (MAXL),
    .DEF_LEVEL (DEFL),
    .STEP      (STEP)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_up   (key_up),
    .key_down (key_down),
    .key_mute (key_mute),
    .vol_level(vol_level),
    .muted    (muted),
    .vol_data (vol_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Keys are seen two clocks late (synchronizer); every SD-th clock is a sample.
  // A key is "down" after DL consecutive high samples and "up" after DL low
  // ones; it only counts as pressed if it was seen up for DL samples first.
  // Up/down pulse once on press, then RD ticks after the press tick, then
  // every RP ticks while still down. Mute pulses only on press.
  int          m_level;
  bit          m_muted;
  logic [31:0] m_data;
  int          e_cnt;
  bit          d1[3], d2[3];
  int          ones_run[3], zeros_run[3];
  bit          deb[3], armed[3], rose_pend[3];
  int          rose_tick[3], press_tick[3];

  function automatic logic [31:0] amp_pair(input int level, input bit mute);
    logic [15:0] a;
    a = mute ? 16'h0000 : 16'(level * int'(STEP));
    return {a, 16'h0000 - a};
  endfunction

  task automatic model_reset();
    m_level = DEFL;
    m_muted = 1'b0;
    m_data  = amp_pair(DEFL, 1'b0);
    e_cnt   = 0;
    for (int k = 0; k < 3; k++) begin
      d1[k] = 0; d2[k] = 0; ones_run[k] = 0; zeros_run[k] = 0;
      deb[k] = 0; armed[k] = 0; rose_pend[k] = 0; rose_tick[k] = 0; press_tick[k] = -1;
    end
  endtask

  task automatic model_step();
    bit keys[3];
    bit pulse[3];
    bit tick;
    int t;
    keys  = '{key_up, key_down, key_mute};
    e_cnt++;
    tick  = (e_cnt % SD) == 0;
    t     = e_cnt / SD;
    for (int k = 0; k < 3; k++) begin
      pulse[k] = 0;
      if (rose_pend[k]) begin
        pulse[k]      = 1;
        rose_pend[k]  = 0;
        press_tick[k] = rose_tick[k];
      end
      if (tick) begin
        if (k != 2 && deb[k] && press_tick[k] >= 0 && (t - press_tick[k]) >= RD
            && ((t - press_tick[k] - RD) % RP) == 0)
          pulse[k] = 1;
        if (d2[k]) begin ones_run[k]++; zeros_run[k] = 0; end
        else       begin zeros_run[k]++; ones_run[k] = 0; end
        if (ones_run[k] >= DL && !deb[k]) begin
          deb[k] = 1;
          if (armed[k]) begin rose_pend[k] = 1; rose_tick[k] = t; end
        end else if (zeros_run[k] >= DL) begin
          deb[k] = 0; armed[k] = 1; press_tick[k] = -1;
        end
      end
      d2[k] = d1[k];
      d1[k] = keys[k];
    end
    m_data = amp_pair(m_level, m_muted);
    if (pulse[0] && !pulse[1])      m_level = (m_level < MAXL) ? m_level + 1 : MAXL;
    else if (pulse[1] && !pulse[0]) m_level = (m_level > 0) ? m_level - 1 : 0;
    if (pulse[2]) m_muted = !m_muted;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  bit cmp_en = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && cmp_en) begin
        check("cyc_level", 32'(vol_level), 32'(m_level));
        check("cyc_muted", 32'(muted), 32'(m_muted));
        check("cyc_data", vol_data, m_data);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle_ticks(input int n);
    repeat (n * SD) @(negedge clk);
  endtask

  task automatic set_keys(input bit u, input bit d, input bit m);
    key_up = u; key_down = d; key_mute = m;
  endtask

  task automatic press(input bit u, input bit d, input bit m, input int hold);
    set_keys(u, d, m);
    idle_ticks(hold);
    set_keys(0, 0, 0);
    idle_ticks(DL + 3);
  endtask

  task automatic check_out(input string tag, input int lvl, input bit mu, input logic [31:0] data);
    check({tag, "_level"}, 32'(vol_level), 32'(lvl));
    check({tag, "_muted"}, 32'(muted), 32'(mu));
    check({tag, "_data"}, vol_data, data);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_out("in_reset", 8, 0, 32'h2000_E000);
    check("model_reset_data", m_data, 32'h2000_E000);
    rst_n  = 1'b1;
    cmp_en = 1'b1;
    idle_ticks(6);
    check_out("after_reset", 8, 0, 32'h2000_E000);

    press(1, 0, 0, 6);   check_out("single_up", 9, 0, 32'h2400_DC00);
    check("model_single_up", m_data, 32'h2400_DC00);
    press(0, 1, 0, 2);   check_out("glitch_down", 9, 0, 32'h2400_DC00);
    press(1, 0, 0, 60);  check_out("sat_up", 15, 0, 32'h3C00_C400);
    check("model_sat_up", m_data, 32'h3C00_C400);
    press(0, 1, 0, 100); check_out("sat_down", 0, 0, 32'h0000_0000);
    press(1, 0, 0, 6);
    press(1, 0, 0, 6);   check_out("two_up", 2, 0, 32'h0800_F800);
    press(0, 0, 1, 20);  check_out("mute_on", 2, 1, 32'h0000_0000);
    press(1, 0, 0, 6);   check_out("up_muted", 3, 1, 32'h0000_0000);
    press(0, 0, 1, 6);   check_out("mute_off", 3, 0, 32'h0C00_F400);
    press(1, 1, 0, 20);  check_out("up_down_same", 3, 0, 32'h0C00_F400);
    press(1, 0, 1, 6);   check_out("up_mute_same", 4, 1, 32'h0000_0000);
    press(0, 0, 1, 6);   check_out("unmute", 4, 0, 32'h1000_F000);

    // Reset while up is in auto-repeat, with the key still held afterwards.
    set_keys(1, 0, 0);
    idle_ticks(20);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_out("async_reset", 8, 0, 32'h2000_E000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle_ticks(20);      check_out("held_after_reset", 8, 0, 32'h2000_E000);
    set_keys(0, 0, 0);
    idle_ticks(DL + 3);  check_out("released_after_reset", 8, 0, 32'h2000_E000);
    press(1, 0, 0, 6);   check_out("repress", 9, 0, 32'h2400_DC00);

    for (int i = 0; i < 40; i++) begin
      logic [2:0] combo;
      combo = 3'($urandom_range(1, 7));
      set_keys(combo[0], combo[1], combo[2]);
      idle_ticks($urandom_range(1, 30));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      set_keys(0, 0, 0);
      idle_ticks($urandom_range(1, 12));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    idle_ticks(DL + 3);

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
